// File: rtl/serdes_pkg.sv
// Shared types, constants and helpers for the serializer and its bit counter.
package serdes_pkg;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;

  localparam int DEFAULT_LENGTH = 24;

  // The parity helper works on a fixed-width word. A narrower word is zero-extended,
  // which does not change its parity.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/ser_bit_counter.sv
// Down-counter for the bits left in a frame. It stops at zero and reports when it is there.
module ser_bit_counter #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] iv_load_val,
  input  logic         i_load,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // A load wins over a decrement. The counter saturates at zero instead of wrapping.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= iv_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/serializer.sv
// LSB-first parallel-to-serial converter with a valid/ready input and a last-bit marker.
// Defining SERIALIZER_PARITY_EN appends an even-parity bit after the MSB.
module serializer
  import serdes_pkg::*;
#(
  parameter int LENGTH = DEFAULT_LENGTH
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din_valid,
  input  logic [LENGTH-1:0] iv_din,
  output logic              o_ready,
  output logic              o_dout,
  output logic              o_dout_active,
  output logic              o_dout_last,
  output ser_state_t        o_dbg_state
);

`ifdef SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = LENGTH + 1;
`else
  localparam int FRAME_LEN = LENGTH;
`endif
  localparam int CW = $clog2(FRAME_LEN);

  // Handshake: a word transfers at a rising edge where i_en, i_din_valid and o_ready
  // are all high. o_ready is combinational, so a new word can be taken on the final
  // bit of the current frame and the next frame follows with no gap.
  ser_state_t             r_state;
  ser_state_t             w_next_state;
  logic [FRAME_LEN-1:0]   r_shreg;
  logic [FRAME_LEN-1:0]   w_load_word;
  logic                   w_zero;
  logic                   w_last;
  logic                   w_ready;
  logic                   w_accept;
  logic                   w_cnt_en;

`ifdef SERIALIZER_PARITY_EN
  assign w_load_word = {even_parity(PARITY_MAX_W'(iv_din)), iv_din};
`else
  assign w_load_word = iv_din;
`endif

  assign w_last   = (r_state == SHIFT) && w_zero;
  assign w_ready  = !i_rst && ((r_state == IDLE) || (w_last && i_en));
  assign w_accept = i_en && i_din_valid && w_ready;
  assign w_cnt_en = i_en && (r_state == SHIFT);

  ser_bit_counter #(
    .W (CW)
  ) u_bit_counter (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .iv_load_val (CW'(FRAME_LEN - 1)),
    .i_load      (w_accept),
    .i_en        (w_cnt_en),
    .o_zero      (w_zero)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next_state = SHIFT;
      SHIFT:   if (i_en && w_zero && !w_accept) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // The last bit shifts out as zeros fill in from the top, so o_dout rests at 0 in IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_shreg <= w_load_word;
      end else if (w_cnt_en) begin
        r_shreg <= {1'b0, r_shreg[FRAME_LEN-1:1]};
      end
    end
  end

  assign o_ready       = w_ready;
  assign o_dout        = r_shreg[0];
  assign o_dout_active = (r_state == SHIFT);
  assign o_dout_last   = w_last;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_serializer.sv
// Bench for serializer: directed frame, back-to-back, stall and reset scenarios, and a
// randomized stream checked against a receiver model that rebuilds words from the bit stream.
module tb_serializer;
  import serdes_pkg::*;

  localparam int LENGTH = 24;
`ifdef SERIALIZER_PARITY_EN
  localparam int FL = LENGTH + 1;
`else
  localparam int FL = LENGTH;
`endif

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              din_valid;
  logic [LENGTH-1:0] din;
  logic              o_ready;
  logic              o_dout;
  logic              o_dout_active;
  logic              o_dout_last;
  ser_state_t        dbg_state;

  always #5 clk = ~clk;

  serializer #(.LENGTH(LENGTH)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_en          (en),
    .i_din_valid   (din_valid),
    .iv_din        (din),
    .o_ready       (o_ready),
    .o_dout        (o_dout),
    .o_dout_active (o_dout_active),
    .o_dout_last   (o_dout_last),
    .o_dbg_state   (dbg_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model ----------------
  // A frame is the word LSB first, followed by its even-parity bit when parity is on.
  function automatic logic [FL-1:0] ref_frame(input logic [LENGTH-1:0] w);
`ifdef SERIALIZER_PARITY_EN
    ref_frame = {^w, w};
`else
    ref_frame = w;
`endif
  endfunction

  // ---------------- receiver model / scoreboard ----------------
  logic [FL-1:0] exp_q[$];
  logic [FL-1:0] rx_q[$];
  int            rx_len_q[$];
  logic          rx_bits[$];
  logic [FL-1:0] mon_frame;

  // A bit is consumed on every enabled cycle with o_dout_active; a reset drops a partial frame.
  always @(negedge clk) begin
    if (rst) begin
      rx_bits.delete();
    end else if (o_dout_active && en) begin
      rx_bits.push_back(o_dout);
      if (o_dout_last) begin
        mon_frame = '0;
        for (int i = 0; i < FL && i < rx_bits.size(); i++) mon_frame[i] = rx_bits[i];
        rx_q.push_back(mon_frame);
        rx_len_q.push_back(rx_bits.size());
        rx_bits.delete();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; din_valid = 1'b1; din = LENGTH'($urandom);
    cyc(); cyc();
    vectors++; if (o_dout !== 1'b0) begin miscompares++; $display("FAIL reset_dout: got %b want 0", o_dout); end
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL reset_active: got %b want 0", o_dout_active); end
    vectors++; if (o_dout_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b want 0", o_dout_last); end
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready_in_rst: got %b want 0", o_ready); end
    din_valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready_after: got %b want 1", o_ready); end
    cyc();
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL reset_idle_active: got %b want 0", o_dout_active); end
  endtask

  // One isolated frame from IDLE: bit order, active window, last marker, ready and latency.
  task automatic test_frame(input string name, input logic [LENGTH-1:0] w);
    logic [FL-1:0] e;
    logic          exp_l;
    int            lat;
    e = ref_frame(w);
    din = w; din_valid = 1'b1; en = 1'b1;
    #1;
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL %s_idle_ready: got %b want 1", name, o_ready); end
    cyc(); lat = 1;
    din_valid = 1'b0; din = LENGTH'($urandom);
    for (int k = 0; k < FL; k++) begin
      exp_l = (k == FL - 1);
      vectors++; if (o_dout_active !== 1'b1) begin miscompares++; $display("FAIL %s_active bit %0d: got %b want 1", name, k, o_dout_active); end
      vectors++; if (o_dout !== e[k]) begin miscompares++; $display("FAIL %s_dout bit %0d: got %b want %b", name, k, o_dout, e[k]); end
      vectors++; if (o_dout_last !== exp_l) begin miscompares++; $display("FAIL %s_last bit %0d: got %b want %b", name, k, o_dout_last, exp_l); end
      vectors++; if (o_ready !== exp_l) begin miscompares++; $display("FAIL %s_ready bit %0d: got %b want %b", name, k, o_ready, exp_l); end
      if (k < FL - 1) begin cyc(); lat++; din = LENGTH'($urandom); end
    end
    vectors++; if (lat !== FL) begin miscompares++; $display("FAIL %s_latency: got %0d want %0d", name, lat, FL); end
    cyc();
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL %s_post_active: got %b want 0", name, o_dout_active); end
    vectors++; if (o_dout_last !== 1'b0) begin miscompares++; $display("FAIL %s_post_last: got %b want 0", name, o_dout_last); end
  endtask

  task automatic test_single();
    test_frame("single", 24'hA5C3F1);
  endtask

  task automatic test_back_to_back();
    logic [2*FL-1:0] s;
    logic            exp_l;
    s = {ref_frame(24'hFFFFFF), ref_frame(24'h000001)};
    din = 24'h000001; din_valid = 1'b1; en = 1'b1;
    #1;
    cyc();
    din = 24'hFFFFFF;
    for (int k = 0; k < 2 * FL; k++) begin
      exp_l = (k == FL - 1) || (k == 2 * FL - 1);
      vectors++; if (o_dout_active !== 1'b1) begin miscompares++; $display("FAIL b2b_active bit %0d: got %b want 1", k, o_dout_active); end
      vectors++; if (o_dout !== s[k]) begin miscompares++; $display("FAIL b2b_dout bit %0d: got %b want %b", k, o_dout, s[k]); end
      vectors++; if (o_dout_last !== exp_l) begin miscompares++; $display("FAIL b2b_last bit %0d: got %b want %b", k, o_dout_last, exp_l); end
      vectors++; if (o_ready !== exp_l) begin miscompares++; $display("FAIL b2b_ready bit %0d: got %b want %b", k, o_ready, exp_l); end
      if (k < 2 * FL - 1) begin
        cyc();
        if (k == FL - 1) begin din_valid = 1'b0; din = LENGTH'($urandom); end
      end
    end
    cyc();
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL b2b_post_active: got %b want 0", o_dout_active); end
  endtask

  // Stall mid-frame and again on the last bit, which must stay flagged while held.
  task automatic test_stall();
    logic [FL-1:0] e;
    int            lat;
    e = ref_frame(24'h123456);
    din = 24'h123456; din_valid = 1'b1; en = 1'b1;
    #1;
    cyc(); lat = 1;
    din_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      vectors++; if (o_dout !== e[k]) begin miscompares++; $display("FAIL stall_dout bit %0d: got %b want %b", k, o_dout, e[k]); end
      vectors++; if (o_dout_last !== (k == FL - 1)) begin miscompares++; $display("FAIL stall_last bit %0d: got %b", k, o_dout_last); end
      if (k == 10) begin
        en = 1'b0;
        repeat (3) begin
          cyc(); lat++; din = LENGTH'($urandom);
          vectors++; if (o_dout !== e[10]) begin miscompares++; $display("FAIL stall_hold_dout: got %b want %b", o_dout, e[10]); end
          vectors++; if (o_dout_active !== 1'b1) begin miscompares++; $display("FAIL stall_hold_active: got %b want 1", o_dout_active); end
          vectors++; if (o_dout_last !== 1'b0) begin miscompares++; $display("FAIL stall_hold_last: got %b want 0", o_dout_last); end
          vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_hold_ready: got %b want 0", o_ready); end
        end
        en = 1'b1;
      end
      if (k < FL - 1) begin cyc(); lat++; end
    end
    vectors++; if (lat !== FL + 3) begin miscompares++; $display("FAIL stall_latency: got %0d want %0d", lat, FL + 3); end
    en = 1'b0;
    #1;
    vectors++; if (o_ready !== 1'b0) begin miscompares++; $display("FAIL stall_last_ready: got %b want 0", o_ready); end
    repeat (2) begin
      cyc();
      vectors++; if (o_dout_last !== 1'b1) begin miscompares++; $display("FAIL stall_last_held: got %b want 1", o_dout_last); end
      vectors++; if (o_dout !== e[FL-1]) begin miscompares++; $display("FAIL stall_last_dout: got %b want %b", o_dout, e[FL-1]); end
    end
    en = 1'b1;
    cyc();
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL stall_post_active: got %b want 0", o_dout_active); end
  endtask

  task automatic test_reset_mid();
    logic [FL-1:0] e;
    int            n_last;
    int            rx_before;
    e = ref_frame(24'hABCDEF);
    rx_before = rx_q.size();
    din = 24'hABCDEF; din_valid = 1'b1; en = 1'b1;
    #1;
    cyc();
    din_valid = 1'b0;
    for (int k = 0; k <= 12; k++) begin
      vectors++; if (o_dout !== e[k]) begin miscompares++; $display("FAIL rstmid_dout bit %0d: got %b want %b", k, o_dout, e[k]); end
      if (k < 12) cyc();
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    vectors++; if (o_dout !== 1'b0) begin miscompares++; $display("FAIL rstmid_dout: got %b want 0", o_dout); end
    vectors++; if (o_dout_active !== 1'b0) begin miscompares++; $display("FAIL rstmid_active: got %b want 0", o_dout_active); end
    vectors++; if (o_dout_last !== 1'b0) begin miscompares++; $display("FAIL rstmid_last: got %b want 0", o_dout_last); end
    vectors++; if (o_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready: got %b want 1", o_ready); end
    n_last = 0;
    repeat (FL) begin
      cyc();
      if (o_dout_last === 1'b1) n_last++;
    end
    vectors++; if (n_last !== 0) begin miscompares++; $display("FAIL rstmid_no_last: got %0d pulses want 0", n_last); end
    vectors++; if (rx_q.size() !== rx_before) begin miscompares++; $display("FAIL rstmid_no_frame: got %0d frames want %0d", rx_q.size(), rx_before); end
    test_frame("after_rst", 24'h0F0F0F);
  endtask

  // Random words, random source gaps and random stalls; the receiver model rebuilds each word.
  task automatic test_random_loopback();
    int   n_sent;
    int   cycles;
    int   n_cmp;
    logic accepted;
    exp_q.delete(); rx_q.delete(); rx_len_q.delete();
    n_sent = 0; cycles = 0;
    din_valid = 1'b0;
    while (n_sent < 100 && cycles < 20000) begin
      if (!din_valid && $urandom_range(0, 3) != 0) begin din = LENGTH'($urandom); din_valid = 1'b1; end
      en = ($urandom_range(0, 4) != 0);
      #1;
      accepted = din_valid && en && o_ready;
      if (accepted) begin exp_q.push_back(ref_frame(din)); n_sent++; end
      cyc(); cycles++;
      if (accepted) begin din_valid = 1'b0; din = LENGTH'($urandom); end
    end
    din_valid = 1'b0; en = 1'b1;
    while (rx_q.size() < exp_q.size() && cycles < 20000) begin cyc(); cycles++; end
    vectors++; if (cycles >= 20000) begin miscompares++; $display("FAIL loop_timeout: got %0d cycles want < 20000", cycles); end
    vectors++; if (rx_q.size() !== 100) begin miscompares++; $display("FAIL loop_count: got %0d frames want 100", rx_q.size()); end
    n_cmp = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      vectors++; if (rx_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL loop_word %0d: got %h want %h", i, rx_q[i], exp_q[i]); end
      vectors++; if (rx_len_q[i] !== FL) begin miscompares++; $display("FAIL loop_len %0d: got %0d want %0d", i, rx_len_q[i], FL); end
    end
  endtask

`ifdef SERIALIZER_PARITY_EN
  task automatic test_parity();
    test_frame("parity_one", 24'h000007);
    test_frame("parity_zero", 24'h000003);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid();
`ifdef SERIALIZER_PARITY_EN
    test_parity();
`endif
    test_random_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
